// File: rtl/sync_ram_dp_be.sv
// sync_ram_dp_be: simple dual-port RAM with one write port and one read port on a
// single clock. The write port has byte enables. The read path has 1 or 2 cycles of
// latency and a valid flag. Read-during-write behaviour is set by a parameter.
// An optional clear sequencer zeroes every word after reset is released.
module sync_ram_dp_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int BYTE_WIDTH     = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               init_busy,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  // Parameter legality: a bad configuration must not elaborate.
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sync_ram_dp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sync_ram_dp_be: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_clr_addr;
  logic [ADDR_WIDTH-1:0]   w_clr_addr_next;

  logic                    w_ready;
  logic                    w_wr_fire;
  logic                    w_rd_fire;
  logic                    w_collide;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;

  logic [DATA_WIDTH-1:0]   w_s1_data;
  logic                    r_s1_valid;

  // Clear-sequencer state register. Reset restarts clearing from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RESET;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  // Next-state logic: one word is cleared per clock, and the last word ends the sequence.
  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    case (r_state)
      ST_CLEAR: begin
        w_clr_addr_next = r_clr_addr + ADDR_WIDTH'(1);
        if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        w_state_next = ST_READY;
      end
      default: begin
        w_state_next = ST_RESET;
      end
    endcase
  end

  assign init_busy = (r_state == ST_CLEAR);
  assign w_ready   = (r_state == ST_READY);

  // User requests count only once the array is ready.
  assign w_wr_fire = wr_en & w_ready;
  assign w_rd_fire = rd_en & w_ready;
  assign w_collide = w_wr_fire & w_rd_fire & (wr_addr == rd_addr);

  // The array write port is shared by the clear sequencer and the user. It is
  // held off while rst_n is low, so that a write cannot occur during reset.
  assign w_mem_we   = rst_n & (init_busy | w_wr_fire);
  assign w_mem_addr = init_busy ? r_clr_addr : wr_addr;

  // One narrow memory per byte lane. Each byte enable then maps onto its own
  // write enable, and there are no partial-word writes into a shared array.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    logic [BYTE_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_lane_we;
    logic [BYTE_WIDTH-1:0] w_lane_wdata;
    logic [BYTE_WIDTH-1:0] w_lane_rd;
    logic [BYTE_WIDTH-1:0] r_s1_lane;

    assign w_lane_we    = w_mem_we & (init_busy | wr_be[gi]);
    assign w_lane_wdata = init_busy ? '0 : wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH];

    // In new-data mode, a same-address write to this lane bypasses the array.
    assign w_lane_rd = ((RDW_MODE == 1) && w_collide && wr_be[gi])
                       ? wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH]
                       : r_mem[rd_addr];

    // Lane storage. The contents are not reset; the clear sequencer zeroes them.
    always_ff @(posedge clk) begin
      if (w_lane_we) begin
        r_mem[w_mem_addr] <= w_lane_wdata;
      end
    end

    // First read stage. The registered read holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_lane <= '0;
      end else if (w_rd_fire) begin
        r_s1_lane <= w_lane_rd;
      end
    end

    assign w_s1_data[gi*BYTE_WIDTH +: BYTE_WIDTH] = r_s1_lane;
  end

  // First-stage valid flag. It pulses once for each accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_fire;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic                  r_s2_valid;

    // Output register stage. Data advances only with a valid read, so the
    // output holds its last result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_s1_data;
        end
      end
    end

    assign rd_data  = r_s2_data;
    assign rd_valid = r_s2_valid;
  end else begin : g_lat1
    assign rd_data  = w_s1_data;
    assign rd_valid = r_s1_valid;
  end

endmodule

// File: tb/tb_sync_ram_dp_be.sv
// tb_sync_ram_dp_be: directed test of two variants driven by the same stimulus.
// Variant A uses 1-cycle latency and returns old data on a collision.
// Variant B uses 2-cycle latency and returns new data on a collision.
module tb_sync_ram_dp_be;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic        busy_a;
  logic [31:0] data_a;
  logic        valid_a;
  logic        busy_b;
  logic [31:0] data_b;
  logic        valid_b;

  int checks = 0;
  int errors = 0;

  sync_ram_dp_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .init_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_a), .rd_valid(valid_a)
  );

  sync_ram_dp_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .init_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(data_b), .rd_valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(posedge clk); #1;
    wr_en = 1'b0;
    $display("write addr=%0d data=%h be=%b", a, d, be);
  endtask

  // Variant A returns data one edge after rd_en; variant B returns it one edge later.
  task automatic do_read(input string tag, input logic [3:0] a,
                         input logic [31:0] exp_a, input logic [31:0] exp_b);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check({tag, " A valid"}, 32'(valid_a), 32'd1);
    check({tag, " A data"}, data_a, exp_a);
    check({tag, " B early valid"}, 32'(valid_b), 32'd0);
    @(posedge clk); #1;
    check({tag, " A valid drop"}, 32'(valid_a), 32'd0);
    check({tag, " B valid"}, 32'(valid_b), 32'd1);
    check({tag, " B data"}, data_b, exp_b);
    $display("read addr=%0d A=%h B=%h", a, data_a, data_b);
  endtask

  // Count the edges until init_busy falls, with an upper bound on the wait. When
  // 'drive' is set, keep a write and a read of address 5 pending for the whole
  // busy window.
  task automatic measure_busy(input bit drive, output int cnt, output bit saw_valid);
    cnt = 0;
    saw_valid = 1'b0;
    if (drive) begin
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd5;
    end
    while (cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (valid_a || valid_b) saw_valid = 1'b1;
      if (!busy_a) break;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("busy window = %0d cycles", cnt);
  endtask

  int busy_cnt;
  bit saw_v;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy A", 32'(busy_a), 32'd1);
    check("reset busy B", 32'(busy_b), 32'd1);
    check("reset valid A", 32'(valid_a), 32'd0);
    check("reset data A", data_a, 32'h0);
    check("reset data B", data_b, 32'h0);

    // Clear sequence after reset release
    rst_n = 1'b1;
    measure_busy(1'b0, busy_cnt, saw_v);
    check("clear busy cycles", 32'(busy_cnt), 32'd16);
    check("clear busy B done", 32'(busy_b), 32'd0);
    for (int i = 0; i < 16; i++) begin
      do_read($sformatf("clear rd%0d", i), 4'(i), 32'h0, 32'h0);
    end

    // Full-word write and read
    do_write(4'd1, 32'hA5A5_3CFF, 4'hF);
    do_read("full word", 4'd1, 32'hA5A5_3CFF, 32'hA5A5_3CFF);

    // Byte-enable merge
    do_write(4'd2, 32'h1122_3344, 4'hF);
    do_write(4'd2, 32'hAABB_CCDD, 4'b0101);
    do_read("be merge", 4'd2, 32'h11BB_33DD, 32'h11BB_33DD);

    // A write with wr_be = 0 must leave the word unchanged
    do_write(4'd1, 32'h0000_0000, 4'h0);
    do_read("be zero", 4'd1, 32'hA5A5_3CFF, 32'hA5A5_3CFF);

    // Same-address collision: A returns the old word, B returns the new word
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd3;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check("collide A valid", 32'(valid_a), 32'd1);
    check("collide A old", data_a, 32'h0000_0000);
    @(posedge clk); #1;
    check("collide B valid", 32'(valid_b), 32'd1);
    check("collide B new", data_b, 32'hFFFF_FFFF);
    $display("collision addr=3 A=%h B=%h", data_a, data_b);
    do_read("after collide", 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Back-to-back reads of addresses 1, 2 and 3
    rd_en = 1'b1; rd_addr = 4'd1;
    @(posedge clk); #1;
    check("stream e0 A", data_a, 32'hA5A5_3CFF);
    check("stream e0 B valid", 32'(valid_b), 32'd0);
    rd_addr = 4'd2;
    @(posedge clk); #1;
    check("stream e1 A", data_a, 32'h11BB_33DD);
    check("stream e1 B valid", 32'(valid_b), 32'd1);
    check("stream e1 B", data_b, 32'hA5A5_3CFF);
    rd_addr = 4'd3;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("stream e2 A", data_a, 32'hFFFF_FFFF);
    check("stream e2 B valid", 32'(valid_b), 32'd1);
    check("stream e2 B", data_b, 32'h11BB_33DD);
    @(posedge clk); #1;
    check("stream e3 A valid", 32'(valid_a), 32'd0);
    check("stream e3 A hold", data_a, 32'hFFFF_FFFF);
    check("stream e3 B valid", 32'(valid_b), 32'd1);
    check("stream e3 B", data_b, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("stream e4 B valid", 32'(valid_b), 32'd0);
    check("stream e4 B hold", data_b, 32'hFFFF_FFFF);
    $display("stream done A=%h B=%h", data_a, data_b);

    // Reset while a read is still in flight
    rd_en = 1'b1; rd_addr = 4'd1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("pend A valid", 32'(valid_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("pend rst A valid", 32'(valid_a), 32'd0);
    check("pend rst A data", data_a, 32'h0);
    check("pend rst B valid", 32'(valid_b), 32'd0);
    check("pend rst B data", data_b, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("pend rst B held", 32'(valid_b), 32'd0);
    rst_n = 1'b1;
    $display("reset with pending read");

    // Reset during clear step 7, then restart with pending accesses while busy
    repeat (7) @(posedge clk);
    #1;
    check("mid clear busy", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid clear rst busy", 32'(busy_a), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    measure_busy(1'b1, busy_cnt, saw_v);
    check("reclear busy cycles", 32'(busy_cnt), 32'd16);
    check("busy no valid", 32'(saw_v), 32'd0);
    do_read("ignored write", 4'd5, 32'h0, 32'h0);
    do_read("recleared addr1", 4'd1, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_ram_dp_be.md
Name: sync_ram_dp_be

Overview:
- Parametrised successor to the single-port synchronous RAM.
- Simple dual-port memory: one write port and one read port, both on a single clock.
- Write port has byte-enables.
- Read path has selectable latency (1 or 2 cycles) and a read-valid flag.
- Read-during-write collision behaviour is selectable by parameter.
- A built-in clear sequencer zeroes the whole array after reset.
- Used as the general scratch/buffer RAM below FIFOs and register files.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per byte-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1, rd_en-to-rd_data latency in clocks; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write collision: 0 = old data, 1 = new (merged) data.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset release; 0 = skip clearing.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- init_busy, output, 1, high while the clear sequencer runs; ports are ignored while high.
- wr_en, input, 1, write request.
- wr_addr, input, ADDR_WIDTH, write address.
- wr_be, input, NUM_BYTES, byte-enables; bit i selects bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_data, input, DATA_WIDTH, write data.
- rd_en, input, 1, read request.
- rd_addr, input, ADDR_WIDTH, read address.
- rd_data, output, DATA_WIDTH, read data.
- rd_valid, output, 1, one-cycle pulse marking rd_data as valid for one read.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset asserted:
  - rd_data = 0, rd_valid = 0, all read-pipeline stages = 0.
  - FSM enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
  - init_busy = 1 when entering CLEAR, 0 when entering READY.
  - Memory array contents are not reset asynchronously.
- FSM states:
  - CLEAR: one word per clock is written with all zeros, at clr_addr = 0, 1, ..., DEPTH-1.
  - CLEAR -> READY on the edge that writes DEPTH-1. init_busy falls with that same edge.
  - Total busy time is exactly DEPTH cycles after the first clk edge following rst_n release.
  - READY: normal operation. The FSM stays in READY until the next reset.
- Reset during CLEAR aborts the sequence; clearing restarts from address 0 after release.
- While init_busy = 1:
  - wr_en and rd_en are ignored; no user write reaches the array.
  - rd_valid stays 0.
- Write:
  - On a clock edge with wr_en = 1 in READY, each byte lane whose wr_be bit is 1 takes wr_data.
  - Lanes whose wr_be bit is 0 keep their old value.
  - wr_be = 0 is a legal no-op.
- Read:
  - rd_en sampled at edge N (READY).
  - RD_LATENCY = 1: rd_data and rd_valid update at edge N.
  - RD_LATENCY = 2: rd_data and rd_valid update at edge N+1 via an output register stage.
  - Back-to-back reads give one result per cycle, fully pipelined.
- rd_data holds its last value when no read completes; only rd_valid drops.
- Collision (wr_en and rd_en in the same cycle, wr_addr == rd_addr):
  - RDW_MODE 0: the read returns the pre-write word.
  - RDW_MODE 1: the read returns the post-write word, i.e. enabled lanes from wr_data and other lanes old.
- Different addresses in the same cycle are fully independent.
- Reads in flight when reset asserts are discarded; no rd_valid is produced for them.
- Addresses wrap naturally within DEPTH; there is no out-of-range case.
- Illegal RD_LATENCY or a non-multiple DATA_WIDTH must stop elaboration (generate-time error).

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=4, BYTE_WIDTH=8):
- Clear sequence: release rst_n; init_busy is high for exactly 16 cycles. Then read addresses 0..15 -> each returns 32'h0000_0000 with rd_valid.
- Full-word write/read (RD_LATENCY=1): write 32'hA5A5_3CFF to addr 1, then read addr 1 -> rd_data = 32'hA5A5_3CFF with rd_valid, 1 cycle after rd_en.
- Byte-enable merge: addr 2 holds 32'h1122_3344; write 32'hAABB_CCDD with wr_be=4'b0101 -> read returns 32'h11BB_33DD.
- Collision: addr 3 holds 32'h0; same-cycle write of 32'hFFFF_FFFF (be=4'hF) and read of addr 3 -> RDW_MODE 0 returns 32'h0; RDW_MODE 1 returns 32'hFFFF_FFFF.
- Latency 2 streaming: RD_LATENCY=2, reads of addr 1,2,3 on consecutive cycles -> three consecutive rd_valid pulses starting 2 cycles after the first rd_en, data in order. rd_data holds the last value afterwards.
- Reset mid-operation: assert rst_n low at clear step 7 and at a pending read.
  - rd_valid and rd_data go to 0 immediately.
  - After release, init_busy is high for 16 cycles again.
  - Accesses during busy (write 32'hDEAD_BEEF to addr 5) have no effect; addr 5 reads 32'h0.
